// File: rtl/noc_port_arb_if.sv
// -----------------------------------------------------------------------------
// noc_port_arb_if
//   Bundles the AXI4-Stream signals around one router output-port arbiter:
//   the N_IN competing input streams and the single shared output stream.
//
//   Parameters
//     N_IN    number of competing input streams
//     DATA_W  tdata width
//     DEST_W  tdest width
//
//   Signals
//     in_tvalid/in_tready/in_tlast  [N_IN]        per-input handshake and last
//     in_tdata   [N_IN*DATA_W]  input i in bits [i*DATA_W +: DATA_W]
//     in_tdest   [N_IN*DEST_W]  input i in bits [i*DEST_W +: DEST_W]
//     out_tvalid/out_tready/out_tlast             shared output handshake and last
//     out_tdata  [DATA_W], out_tdest [DEST_W]     shared output payload
//
//   Modports
//     master  arbiter view: sinks the inputs, sources the output stream
//     slave   surrounding router view: sources the inputs, sinks the output
// -----------------------------------------------------------------------------
interface noc_port_arb_if #(
    parameter int N_IN   = 5,
    parameter int DATA_W = 64,
    parameter int DEST_W = 4
);
    logic [N_IN-1:0]        in_tvalid;
    logic [N_IN-1:0]        in_tready;
    logic [N_IN-1:0]        in_tlast;
    logic [N_IN*DATA_W-1:0] in_tdata;
    logic [N_IN*DEST_W-1:0] in_tdest;

    logic                   out_tvalid;
    logic                   out_tready;
    logic                   out_tlast;
    logic [DATA_W-1:0]      out_tdata;
    logic [DEST_W-1:0]      out_tdest;

    modport master (
        input  in_tvalid, in_tlast, in_tdata, in_tdest,
        output in_tready,
        output out_tvalid, out_tlast, out_tdata, out_tdest,
        input  out_tready
    );

    modport slave (
        output in_tvalid, in_tlast, in_tdata, in_tdest,
        input  in_tready,
        input  out_tvalid, out_tlast, out_tdata, out_tdest,
        output out_tready
    );
endinterface

// File: rtl/noc_port_arb.sv
// -----------------------------------------------------------------------------
// noc_port_arb
//   Packet-locked round-robin arbiter sharing one AXI4-Stream output port among
//   N_IN input streams. One input is granted per packet; the grant is held until
//   the beat carrying tlast is accepted, then priority rotates past the owner.
//   Beats pass through combinationally; nothing is stored but the grant.
//
//   Optional feature (macro NOC_ARB_WDOG_EN): a stall watchdog counts LOCK
//   cycles in which the owner presents no valid beat and raises a sticky
//   wdog_err_o when the count reaches WDOG_MAX. Without the macro no counter
//   exists and wdog_err_o is tied low.
//
//   Ports
//     clk         clock, rising edge
//     rst_n       asynchronous active-low reset
//     port_if     noc_port_arb_if.master: input streams and shared output stream
//     grant_o     one-hot current owner, zero when idle
//     busy_o      a packet is locked
//     wdog_err_o  sticky stall error
// -----------------------------------------------------------------------------
module noc_port_arb #(
    parameter int N_IN     = 5,
    parameter int DATA_W   = 64,
    parameter int DEST_W   = 4,
    parameter int WDOG_MAX = 1023
) (
    input  logic            clk,
    input  logic            rst_n,
    noc_port_arb_if.master  port_if,
    output logic [N_IN-1:0] grant_o,
    output logic            busy_o,
    output logic            wdog_err_o
);
    localparam int PTR_W = $clog2(N_IN);

    if (N_IN < 2 || WDOG_MAX < 1) begin : g_bad_param
        $error("noc_port_arb: N_IN must be >= 2 and WDOG_MAX >= 1");
    end

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    // Owner view decoded from the one-hot grant.
    logic [PTR_W-1:0]  owner_idx;
    logic [DATA_W-1:0] owner_data;
    logic [DEST_W-1:0] owner_dest;
    logic              owner_valid;
    logic              owner_last;
    logic              beat_fire;
    logic              pkt_done;

    // Round-robin candidate for the next packet.
    logic [N_IN-1:0]   pick_grant;
    logic              pick_found;
    logic [PTR_W-1:0]  cand;

    // grant_q is zero in IDLE, so these collapse to 0 there without gating.
    assign owner_valid = |(port_if.in_tvalid & grant_q);
    assign owner_last  = |(port_if.in_tlast & grant_q);
    assign beat_fire   = owner_valid & port_if.out_tready;
    assign pkt_done    = beat_fire & owner_last;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can leave it unassigned and infer a latch.
        owner_idx  = '0;
        owner_data = '0;
        owner_dest = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant_q[i]) begin
                owner_idx  = PTR_W'(i);
                owner_data = port_if.in_tdata[i*DATA_W +: DATA_W];
                owner_dest = port_if.in_tdest[i*DEST_W +: DEST_W];
            end
        end
    end

    // Search upward from ptr+1 (wrapping) so the last owner has lowest priority.
    always_comb begin
        pick_grant = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int k = 1; k <= N_IN; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % N_IN);
            if (!pick_found && port_if.in_tvalid[cand]) begin
                pick_grant[cand] = 1'b1;
                pick_found       = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(N_IN - 1);  // input 0 has first priority after reset
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|port_if.in_tvalid) begin
                    state_d = ST_LOCK;
                    grant_d = pick_grant;
                end
            end
            ST_LOCK: begin
                // Release only on the accepted last beat; a source dropping
                // tvalid mid-packet keeps the lock.
                if (pkt_done) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = owner_idx;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output logic: pass-through mux from the owner, zeros when idle.
    always_comb begin
        port_if.out_tvalid = 1'b0;
        port_if.out_tlast  = 1'b0;
        port_if.out_tdata  = '0;
        port_if.out_tdest  = '0;
        port_if.in_tready  = '0;
        if (state_q == ST_LOCK) begin
            port_if.out_tvalid = owner_valid;
            port_if.out_tlast  = owner_last;
            port_if.out_tdata  = owner_data;
            port_if.out_tdest  = owner_dest;
            port_if.in_tready  = grant_q & {N_IN{port_if.out_tready}};
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == ST_LOCK);

`ifdef NOC_ARB_WDOG_EN
    localparam int                WDOG_W     = $clog2(WDOG_MAX + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_MAX);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;

    // Counts owner-idle LOCK cycles; any accepted beat (including the release
    // beat) or being in IDLE clears it. The lock itself is never broken.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if ((state_q != ST_LOCK) || beat_fire) begin
            wdog_cnt_d = '0;
        end else if (!owner_valid && (wdog_cnt_q != WDOG_LIMIT)) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
        wdog_err_d = wdog_err_q | (wdog_cnt_d == WDOG_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err_o = wdog_err_q;
`else
    assign wdog_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_port_arb.sv
// -----------------------------------------------------------------------------
// tb_noc_port_arb
//   Self-checking bench for noc_port_arb (N_IN=5, DATA_W=64, DEST_W=4,
//   WDOG_MAX=8). Sources hold whole packets in per-input queues. A reference
//   model decides packet ownership with round-robin integer arithmetic and,
//   on each grant, pushes the owner's packet beats into a scoreboard queue;
//   an independent monitor pops and compares on every output handshake.
//   Directed scenarios precede a randomized stall/backpressure run.
//   Watchdog expectations follow NOC_ARB_WDOG_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_noc_port_arb;
    localparam int N        = 5;
    localparam int DW       = 64;
    localparam int TW       = 4;
    localparam int WDOG_MAX = 8;
`ifdef NOC_ARB_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] dest;
        logic          last;
    } beat_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] grant_o;
    logic         busy_o;
    logic         wdog_err_o;

    noc_port_arb_if #(.N_IN(N), .DATA_W(DW), .DEST_W(TW)) port_if ();

    noc_port_arb #(
        .N_IN(N), .DATA_W(DW), .DEST_W(TW), .WDOG_MAX(WDOG_MAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .port_if(port_if),
        .grant_o(grant_o),
        .busy_o(busy_o),
        .wdog_err_o(wdog_err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    beat_t        src_q [N][$];
    beat_t        exp_q [$];
    int           vmode [N];     // 0: random valid, 1: valid whenever queued, 2: held low
    int           v_pct = 70;
    int           r_pct = 100;
    logic [N-1:0] fired = '0;
    int           pkt_seq = 0;
    int           owners [$];
    int           busy_cnt = 0;

    // Reference model state.
    int           m_owner = -1;
    int           m_ptr   = N - 1;
    int           m_cnt   = 0;
    bit           m_err   = 1'b0;
    int           m_idx;
    int           m_o;
    logic [N-1:0] m_oh;
    bit           m_fire;
    beat_t        mon_b;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int src, input int len);
        for (int b = 0; b < len; b++) begin
            beat_t bt;
            bt.data = {8'(src), 24'(pkt_seq), 16'(b), 16'($urandom)};
            bt.dest = TW'($urandom);
            bt.last = (b == len - 1);
            src_q[src].push_back(bt);
        end
        pkt_seq++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        fired = '0;
        for (int i = 0; i < N; i++) begin
            logic v;
            v = 1'b0;
            if (src_q[i].size() > 0) begin
                case (vmode[i])
                    0:       v = (int'($urandom_range(99)) < v_pct);
                    1:       v = 1'b1;
                    default: v = 1'b0;
                endcase
                port_if.in_tdata[i*DW +: DW] = src_q[i][0].data;
                port_if.in_tdest[i*TW +: TW] = src_q[i][0].dest;
                port_if.in_tlast[i]          = src_q[i][0].last;
            end else begin
                port_if.in_tdata[i*DW +: DW] = '0;
                port_if.in_tdest[i*TW +: TW] = '0;
                port_if.in_tlast[i]          = 1'b0;
            end
            port_if.in_tvalid[i] = v;
        end
        port_if.out_tready = (int'($urandom_range(99)) < r_pct);
    endtask

    // One clock cycle: drive after the edge, record handshakes at the negedge.
    task automatic step();
        drive();
        @(negedge clk);
        fired = port_if.in_tvalid & port_if.in_tready;
        @(posedge clk);
        #1;
    endtask

    task automatic set_vmode(input int m);
        for (int i = 0; i < N; i++) vmode[i] = m;
    endtask

    // Asynchronous assertion mid-cycle; the caller releases rst_n.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_outputs",
              {grant_o, busy_o, wdog_err_o, port_if.out_tvalid, port_if.out_tlast,
               port_if.out_tdata, port_if.out_tdest, port_if.in_tready}, '0);
        fired = '0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic bit pending();
        bit p;
        p = busy_o || (exp_q.size() != 0) || (fired != '0);
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Steps until all queued traffic is delivered, logging new grants and busy cycles.
    task automatic run_drain(input string name, input int max_cycles);
        int           guard = 0;
        logic [N-1:0] prev;
        owners.delete();
        busy_cnt = 0;
        prev     = grant_o;
        while (pending() && guard < max_cycles) begin
            step();
            guard++;
            if (busy_o) busy_cnt++;
            if (grant_o != '0 && prev == '0) owners.push_back(onehot_idx(grant_o));
            prev = grant_o;
        end
        check({name, "_drained"}, 128'(pending()), 128'(0));
    endtask

    // Reference model: packet ownership by round-robin rules, control outputs, watchdog.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = N - 1;
            m_cnt   = 0;
            m_err   = 1'b0;
        end else begin
            check("wdog_err", wdog_err_o, WDOG_ON ? m_err : 1'b0);
            if (m_owner < 0) begin
                check("idle_outputs",
                      {grant_o, busy_o, port_if.out_tvalid, port_if.in_tready,
                       port_if.out_tlast, port_if.out_tdata, port_if.out_tdest}, '0);
                for (int k = 1; k <= N; k++) begin
                    m_idx = (m_ptr + k) % N;
                    if (port_if.in_tvalid[m_idx]) begin
                        m_owner = m_idx;
                        for (int b = 0; b < src_q[m_idx].size(); b++) begin
                            exp_q.push_back(src_q[m_idx][b]);
                            if (src_q[m_idx][b].last) break;
                        end
                        break;
                    end
                end
            end else begin
                m_o      = m_owner;
                m_oh     = '0;
                m_oh[m_o] = 1'b1;
                check("lock_grant", {busy_o, grant_o}, {1'b1, m_oh});
                check("lock_out_tvalid", port_if.out_tvalid, port_if.in_tvalid[m_o]);
                check("lock_in_tready", port_if.in_tready, port_if.out_tready ? m_oh : '0);
                m_fire = port_if.in_tvalid[m_o] && port_if.out_tready;
                if (m_fire) m_cnt = 0;
                else if (!port_if.in_tvalid[m_o] && m_cnt < WDOG_MAX) m_cnt++;
                if (m_cnt == WDOG_MAX) m_err = 1'b1;
                if (m_fire && port_if.in_tlast[m_o]) begin
                    m_ptr   = m_o;
                    m_owner = -1;
                end
            end
        end
    end

    // Scoreboard monitor: every accepted output beat must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && port_if.out_tvalid && port_if.out_tready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_beat: got data %0h, expected no beat (t=%0t)",
                         port_if.out_tdata, $time);
            end else begin
                mon_b = exp_q.pop_front();
                check("sb_beat", {port_if.out_tdata, port_if.out_tdest, port_if.out_tlast}, mon_b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: run exceeded 500000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] held;
        int            s;

        port_if.in_tvalid  = '0;
        port_if.in_tlast   = '0;
        port_if.in_tdata   = '0;
        port_if.in_tdest   = '0;
        port_if.out_tready = 1'b0;
        set_vmode(1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset_state", {grant_o, busy_o, wdog_err_o, port_if.out_tvalid, port_if.in_tready}, '0);

        // Idle, then input 2 raises valid: grant on the next edge, beat in that cycle.
        repeat (4) step();
        push_pkt(2, 2);
        step();
        check("t1_grant", grant_o, 5'b00100);
        step();
        check("t1_first_beat", fired, 5'b00100);
        step();
        step();
        check("t1_released", busy_o, 1'b0);

        // All inputs streaming 3-beat packets: strict rotation, 3 busy cycles per packet.
        apply_reset();
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_pkt(i, 3);
        set_vmode(1);
        r_pct = 100;
        rst_n = 1'b1;
        run_drain("t2", 200);
        check("t2_n_grants", owners.size(), 10);
        for (int k = 0; k < 10; k++) check("t2_owner", owners[k], k % N);
        check("t2_busy_cycles", busy_cnt, 30);

        // Owner 1 backpressured mid-packet while input 3 waits.
        push_pkt(1, 4);
        step();
        check("t3_grant", grant_o, 5'b00010);
        step();
        held = src_q[1][1].data;
        push_pkt(3, 2);
        r_pct = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t3_hold_grant", grant_o, 5'b00010);
            check("t3_hold_data", port_if.out_tdata, held);
            check("t3_no_fire", fired, '0);
        end
        r_pct = 100;
        run_drain("t3", 100);
        check("t3_next_owner", owners[0], 3);

        // Single-beat packets on inputs 0 and 4: one-cycle grants with a bubble each.
        push_pkt(0, 1);
        push_pkt(4, 1);
        push_pkt(0, 1);
        push_pkt(4, 1);
        for (int k = 0; k < 8; k++) begin
            step();
            check("t4_busy", busy_o, (k % 2) == 0);
        end
        run_drain("t4", 20);

        // Reset during beat 2 of a 4-beat packet; input 0 wins afterwards.
        push_pkt(3, 4);
        step();
        step();
        step();
        apply_reset();
        push_pkt(0, 2);
        push_pkt(3, 2);
        rst_n = 1'b1;
        step();
        check("t5_grant_after_reset", grant_o, 5'b00001);
        run_drain("t5", 50);

        // Owner stalls 8 cycles: watchdog flags on the 8th stall edge and stays set.
        apply_reset();
        push_pkt(2, 3);
        rst_n = 1'b1;
        step();
        step();
        vmode[2] = 2;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 6) check("t6_wdog_before", wdog_err_o, 1'b0);
        end
        check("t6_wdog_set", wdog_err_o, WDOG_ON);
        check("t6_lock_held", grant_o, 5'b00100);
        vmode[2] = 1;
        run_drain("t6", 50);
        check("t6_wdog_sticky", wdog_err_o, WDOG_ON);

        // Randomized traffic with source stalls and output backpressure.
        set_vmode(0);
        v_pct = 70;
        r_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(2) == 0) begin
                s = int'($urandom_range(N - 1));
                if (src_q[s].size() < 8) push_pkt(s, int'($urandom_range(4, 1)));
            end
            step();
        end
        set_vmode(1);
        r_pct = 100;
        run_drain("rand", 2000);
        check("final_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/noc_port_arb.md
# noc_port_arb

Packet-locked round-robin arbiter sharing one AXI4-Stream output port of a `noc_nxn_mesh` router among N_IN input streams (local plus the mesh neighbours). It grants one input per packet and holds that grant until the beat carrying `tlast` is accepted. It then rotates priority. One instance sits in front of each router output port, in both the request mesh and the response mesh.

## Interface
- N_IN, 5, number of competing input streams (≥2)
- DATA_W, 64, tdata width
- DEST_W, 4, tdest width (node index, log2 of NODE_N)
- WDOG_MAX, 1023, stall-watchdog threshold in cycles (used only with the watchdog compiled in)

- clk  in  1  clock; everything samples on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_tvalid  in  N_IN  per-input valid
- in_tready  out  N_IN  per-input ready
- in_tlast  in  N_IN  per-input last
- in_tdata  in  N_IN*DATA_W  input i in bits [i*DATA_W +: DATA_W]
- in_tdest  in  N_IN*DEST_W  input i in bits [i*DEST_W +: DEST_W]
- out_tvalid  out  1  output valid
- out_tready  in  1  output ready
- out_tlast  out  1  output last
- out_tdata  out  DATA_W  output data
- out_tdest  out  DEST_W  output destination
- grant_o  out  N_IN  one-hot current owner; all zero when idle
- busy_o  out  1  a packet is locked
- wdog_err_o  out  1  sticky stall error

## Operation
- States:
  - IDLE: no owner.
  - LOCK: one owner, held in a registered one-hot `grant`.
- IDLE → LOCK:
  - Taken when any in_tvalid bit is 1.
  - The owner is the first valid input found searching upward from (ptr+1) mod N_IN.
  - `grant` is registered.
- In LOCK:
  - out_tvalid = in_tvalid[g]; out_tdata, out_tdest and out_tlast are muxed from input g.
  - in_tready[g] = out_tready.
  - in_tready for every other input = 0.
- LOCK → IDLE:
  - Taken on the handshake (out_tvalid & out_tready & out_tlast).
  - On that same edge: ptr ← g, and `grant` ← 0.
- Beat transfer is combinational pass-through; the block stores no data.
- In IDLE: out_tvalid = 0, all in_tready = 0, and the mux outputs are don't-care (driven 0).
- Sources drop tvalid mid-packet: the lock is held, nothing transfers, and no other input is granted.
- A single-beat packet (tvalid and tlast together) locks, transfers and releases like any other packet.
- Reset, including assertion mid-packet:
  - state = IDLE, grant = 0, ptr = N_IN-1 (input 0 has first priority), watchdog counter = 0, wdog_err_o = 0.
  - A packet interrupted by reset is abandoned. No output beat is produced until a new arbitration.

## Timing
- Arbitration latency: a valid seen in IDLE at cycle t is granted at edge t+1. Its first beat can transfer in cycle t+1.
- Release costs one IDLE bubble. If the last beat transfers in cycle t, the next owner's first beat is possible at cycle t+2 at the earliest.
- Peak throughput: P/(P+1) beats/cycle for back-to-back P-beat packets.
- Fairness: with all inputs continuously valid, grants go 0,1,…,N_IN-1,0,… Worst-case wait is N_IN-1 packets.
- in_tready depends combinationally on out_tready. out_tvalid and the mux outputs depend combinationally on the in_* inputs. There are no other combinational paths.
- Output reset values: out_tvalid 0, out_tlast 0, out_tdata 0, out_tdest 0, in_tready 0, grant_o 0, busy_o 0, wdog_err_o 0.

## Configuration
- Macro: `NOC_ARB_WDOG_EN`.
- Defined:
  - A counter of width clog2(WDOG_MAX+1) increments every LOCK cycle with in_tvalid[g] = 0.
  - It clears on any accepted beat and on entry to IDLE. It saturates at WDOG_MAX.
  - On reaching WDOG_MAX, wdog_err_o sets and stays 1 until rst_n.
  - The lock is not broken.
- Undefined: no counter is instantiated and wdog_err_o is tied 0.

## Test plan
- Reset release, idle inputs → all outputs 0. Raise in_tvalid[2] at cycle 5 → grant_o = 5'b00100 from cycle 6, first beat accepted in cycle 6.
- All 5 inputs streaming 3-beat packets, out_tready = 1 → owners 0,1,2,3,4,0; each packet takes 3 cycles followed by 1 idle cycle.
- Owner 1 mid-packet, out_tready low for 4 cycles while input 3 is valid → in_tready = 0, data held stable, grant stays 1; the packet then completes before input 3 is served.
- Single-beat packets alternating on inputs 0 and 4 → each grant lasts exactly 1 cycle, busy_o toggles 1,0,1,0.
- rst_n asserted in beat 2 of a 4-beat packet → all outputs 0 immediately; after release, input 0 wins if it is valid.
- With `NOC_ARB_WDOG_EN` and WDOG_MAX = 8: owner drops tvalid for 8 cycles → wdog_err_o rises on the 8th stall edge and stays 1 after the packet finishes. With the macro undefined, wdog_err_o stays 0.
